// File: rtl/cluster_clkgate_seq.sv
`default_nettype none
// ============================================================================
//  Module   : cluster_clkgate_seq
//  Purpose  : Sequences cluster clock-gate requests into safe clock enables.
//             Each core drains for IDLE_CYCLES idle cycles before its clock
//             is gated. A wake event or a dropped request reopens the clock,
//             and the core is reported running SETTLE_CYCLES cycles later.
//             SCM, interconnect, HW-accelerator and TCDM-port enables are
//             registered as well.
//  Optional : CLKGATE_SEQ_STATS_EN adds a saturating gated-cycle counter
//             (gated_cycles_o) with a synchronous clear (stats_clr_i).
//  Revision : 1.0 - initial release
// ============================================================================
module cluster_clkgate_seq #(
    parameter int NB_CORES      = 4,
    parameter int IDLE_CYCLES   = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                test_mode_i,
    input  logic                clkgate_sel_i,
    input  logic [NB_CORES-1:0] clkgate_core_i,
    input  logic [NB_CORES-1:0] clkgate_tcdm_i,
    input  logic                clkgate_scm_i,
    input  logic                clkgate_int_i,
    input  logic                clkgate_hwacc_i,
    input  logic [NB_CORES-1:0] core_busy_i,
    input  logic [NB_CORES-1:0] tcdm_pending_i,
    input  logic [NB_CORES-1:0] wake_i,
    output logic [NB_CORES-1:0] core_clk_en_o,
    output logic [NB_CORES-1:0] tcdm_clk_en_o,
    output logic                scm_clk_en_o,
    output logic                int_clk_en_o,
    output logic                hwacc_clk_en_o,
    output logic [NB_CORES-1:0] core_gated_o
`ifdef CLKGATE_SEQ_STATS_EN
    ,
    input  logic                stats_clr_i,
    output logic [31:0]         gated_cycles_o
`endif
);

    localparam int c_cnt_max = (IDLE_CYCLES > SETTLE_CYCLES) ? IDLE_CYCLES : SETTLE_CYCLES;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w-1:0] c_cnt_zero    = '0;
    localparam logic [c_cnt_w-1:0] c_cnt_one     = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_idle_last   = c_cnt_w'(IDLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_settle_last = c_cnt_w'(SETTLE_CYCLES - 1);

    localparam logic [1:0] c_st_run   = 2'd0;
    localparam logic [1:0] c_st_drain = 2'd1;
    localparam logic [1:0] c_st_gated = 2'd2;
    localparam logic [1:0] c_st_wake  = 2'd3;

    logic [NB_CORES-1:0] w_req;
    logic [NB_CORES-1:0] w_idle;
    logic [NB_CORES-1:0] w_gated_now;
    logic [NB_CORES-1:0] w_gated_nxt;
    logic [NB_CORES-1:0] w_not_run;

    logic [NB_CORES-1:0] r_tcdm_en;
    logic                r_int_en;
    logic                r_scm_en;
    logic                r_hwacc_en;

    assign w_req  = {NB_CORES{clkgate_sel_i}} & clkgate_core_i;
    assign w_idle = ~core_busy_i & ~tcdm_pending_i;

    generate
        for (genvar i = 0; i < NB_CORES; i++) begin : g_core
            logic [1:0]         r_state;
            logic [1:0]         w_state_nxt;
            logic [c_cnt_w-1:0] r_cnt;
            logic [c_cnt_w-1:0] w_cnt_nxt;

            // Next-state: drain, gate, wake and settle; wake beats request everywhere.
            always_comb begin
                w_state_nxt = r_state;
                w_cnt_nxt   = r_cnt;
                case (r_state)
                    c_st_run: begin
                        if (w_req[i] && !wake_i[i]) begin
                            w_state_nxt = c_st_drain;
                            w_cnt_nxt   = c_cnt_zero;
                        end
                    end
                    c_st_drain: begin
                        if (!w_req[i] || wake_i[i]) begin
                            w_state_nxt = c_st_run;
                            w_cnt_nxt   = c_cnt_zero;
                        end else if (!w_idle[i]) begin
                            w_cnt_nxt   = c_cnt_zero;
                        end else if (r_cnt == c_idle_last) begin
                            w_state_nxt = c_st_gated;
                            w_cnt_nxt   = c_cnt_zero;
                        end else begin
                            w_cnt_nxt   = r_cnt + c_cnt_one;
                        end
                    end
                    c_st_gated: begin
                        if (!w_req[i] || wake_i[i]) begin
                            w_state_nxt = c_st_wake;
                            w_cnt_nxt   = c_cnt_zero;
                        end
                    end
                    default: begin
                        // Settling after reopen: requests are ignored here.
                        if (r_cnt == c_settle_last) begin
                            w_state_nxt = c_st_run;
                            w_cnt_nxt   = c_cnt_zero;
                        end else begin
                            w_cnt_nxt   = r_cnt + c_cnt_one;
                        end
                    end
                endcase
            end

            // Per-core state and counter registers.
            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    r_state <= c_st_run;
                    r_cnt   <= c_cnt_zero;
                end else begin
                    r_state <= w_state_nxt;
                    r_cnt   <= w_cnt_nxt;
                end
            end

            assign w_gated_now[i] = (r_state == c_st_gated);
            assign w_gated_nxt[i] = (w_state_nxt == c_st_gated);
            assign w_not_run[i]   = (r_state != c_st_run);
        end
    endgenerate

    // Shared enables follow the next core state so that a core leaving GATED
    // reopens its TCDM port and the interconnect on the same edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_tcdm_en  <= '1;
            r_int_en   <= 1'b1;
            r_scm_en   <= 1'b1;
            r_hwacc_en <= 1'b1;
        end else begin
            r_tcdm_en  <= ~({NB_CORES{clkgate_sel_i}} & clkgate_tcdm_i & w_gated_nxt);
            r_int_en   <= ~(clkgate_sel_i & clkgate_int_i & (&w_gated_nxt));
            r_scm_en   <= ~(clkgate_sel_i & clkgate_scm_i);
            r_hwacc_en <= ~(clkgate_sel_i & clkgate_hwacc_i);
        end
    end

    // Test mode overrides after the flops; the FSMs keep running underneath.
    assign core_clk_en_o  = ~w_gated_now | {NB_CORES{test_mode_i}};
    assign tcdm_clk_en_o  = r_tcdm_en    | {NB_CORES{test_mode_i}};
    assign int_clk_en_o   = r_int_en     | test_mode_i;
    assign scm_clk_en_o   = r_scm_en     | test_mode_i;
    assign hwacc_clk_en_o = r_hwacc_en   | test_mode_i;
    assign core_gated_o   = w_not_run;

`ifdef CLKGATE_SEQ_STATS_EN
    logic [31:0] r_gated_cycles;

    // Saturating count of cycles with any core clock gated; clear wins.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_gated_cycles <= '0;
        end else if (stats_clr_i) begin
            r_gated_cycles <= '0;
        end else if ((|w_gated_now) && (r_gated_cycles != 32'hFFFF_FFFF)) begin
            r_gated_cycles <= r_gated_cycles + 32'd1;
        end
    end

    assign gated_cycles_o = r_gated_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cluster_clkgate_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cluster_clkgate_seq
//  Purpose  : Self-checking bench for cluster_clkgate_seq: directed gate/wake
//             sequence with literal expectations, then randomized traffic
//             compared every cycle against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cluster_clkgate_seq;

    localparam int NB     = 4;
    localparam int IDLE   = 8;
    localparam int SETTLE = 2;

    logic          clk;
    logic          rst_ni;
    logic          test_mode_i;
    logic          clkgate_sel_i;
    logic [NB-1:0] clkgate_core_i;
    logic [NB-1:0] clkgate_tcdm_i;
    logic          clkgate_scm_i;
    logic          clkgate_int_i;
    logic          clkgate_hwacc_i;
    logic [NB-1:0] core_busy_i;
    logic [NB-1:0] tcdm_pending_i;
    logic [NB-1:0] wake_i;
    logic [NB-1:0] core_clk_en_o;
    logic [NB-1:0] tcdm_clk_en_o;
    logic          scm_clk_en_o;
    logic          int_clk_en_o;
    logic          hwacc_clk_en_o;
    logic [NB-1:0] core_gated_o;
`ifdef CLKGATE_SEQ_STATS_EN
    logic          stats_clr_i;
    logic [31:0]   gated_cycles_o;
`endif

    int n_cmp = 0;
    int n_err = 0;

    cluster_clkgate_seq #(
        .NB_CORES      (NB),
        .IDLE_CYCLES   (IDLE),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .test_mode_i     (test_mode_i),
        .clkgate_sel_i   (clkgate_sel_i),
        .clkgate_core_i  (clkgate_core_i),
        .clkgate_tcdm_i  (clkgate_tcdm_i),
        .clkgate_scm_i   (clkgate_scm_i),
        .clkgate_int_i   (clkgate_int_i),
        .clkgate_hwacc_i (clkgate_hwacc_i),
        .core_busy_i     (core_busy_i),
        .tcdm_pending_i  (tcdm_pending_i),
        .wake_i          (wake_i),
        .core_clk_en_o   (core_clk_en_o),
        .tcdm_clk_en_o   (tcdm_clk_en_o),
        .scm_clk_en_o    (scm_clk_en_o),
        .int_clk_en_o    (int_clk_en_o),
        .hwacc_clk_en_o  (hwacc_clk_en_o),
        .core_gated_o    (core_gated_o)
`ifdef CLKGATE_SEQ_STATS_EN
        ,
        .stats_clr_i     (stats_clr_i),
        .gated_cycles_o  (gated_cycles_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model. Per core: streak = consecutive qualifying idle
    // cycles while a gate request is held (-1 = no request pending),
    // off = clock currently gated, settle = cycles left before reporting
    // the core as running again after a reopen.
    // ------------------------------------------------------------------
    int          m_streak [NB];
    bit          m_off    [NB];
    int          m_settle [NB];
    logic [NB-1:0] m_tcdm_en;
    bit          m_int_en, m_scm_en, m_hwacc_en;
    logic [31:0] m_stats;
    bit          m_valid = 0;

    always @(posedge clk) begin
        if (!rst_ni) begin
            for (int i = 0; i < NB; i++) begin
                m_streak[i] = -1; m_off[i] = 0; m_settle[i] = 0;
            end
            m_tcdm_en = '1; m_int_en = 1; m_scm_en = 1; m_hwacc_en = 1;
            m_stats = 0;
            m_valid = 1;
        end else begin
            bit any_off, all_off;
            any_off = 0;
            for (int i = 0; i < NB; i++) any_off |= m_off[i];
`ifdef CLKGATE_SEQ_STATS_EN
            if (stats_clr_i) m_stats = 0;
            else if (any_off && m_stats != 32'hFFFF_FFFF) m_stats = m_stats + 1;
`endif
            for (int i = 0; i < NB; i++) begin
                bit req, idle, wk;
                req  = clkgate_sel_i && clkgate_core_i[i];
                idle = !core_busy_i[i] && !tcdm_pending_i[i];
                wk   = wake_i[i];
                if (m_settle[i] > 0) begin
                    m_settle[i]--;
                end else if (m_off[i]) begin
                    if (!req || wk) begin m_off[i] = 0; m_settle[i] = SETTLE; end
                end else if (m_streak[i] >= 0) begin
                    if (!req || wk)              m_streak[i] = -1;
                    else if (!idle)              m_streak[i] = 0;
                    else if (m_streak[i] == IDLE - 1) begin m_off[i] = 1; m_streak[i] = -1; end
                    else                         m_streak[i]++;
                end else if (req && !wk) begin
                    m_streak[i] = 0;
                end
            end
            all_off = 1;
            for (int i = 0; i < NB; i++) begin
                all_off &= m_off[i];
                m_tcdm_en[i] = !(clkgate_sel_i && clkgate_tcdm_i[i] && m_off[i]);
            end
            m_int_en   = !(clkgate_sel_i && clkgate_int_i && all_off);
            m_scm_en   = !(clkgate_sel_i && clkgate_scm_i);
            m_hwacc_en = !(clkgate_sel_i && clkgate_hwacc_i);
        end
    end

    // Compare every output against the model on the falling edge.
    always @(negedge clk) begin
        if (m_valid) begin
            logic [NB-1:0] e_core, e_gated;
            for (int i = 0; i < NB; i++) begin
                e_core[i]  = test_mode_i | !m_off[i];
                e_gated[i] = m_off[i] || (m_settle[i] > 0) || (m_streak[i] >= 0);
            end
            check("core_clk_en", 32'(core_clk_en_o), 32'(e_core));
            check("tcdm_clk_en", 32'(tcdm_clk_en_o), 32'(m_tcdm_en | {NB{test_mode_i}}));
            check("int_clk_en",  32'(int_clk_en_o),  32'(m_int_en | test_mode_i));
            check("scm_clk_en",  32'(scm_clk_en_o),  32'(m_scm_en | test_mode_i));
            check("hwacc_clk_en",32'(hwacc_clk_en_o),32'(m_hwacc_en | test_mode_i));
            check("core_gated",  32'(core_gated_o),  32'(e_gated));
`ifdef CLKGATE_SEQ_STATS_EN
            check("gated_cycles", gated_cycles_o, m_stats);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_ni = 0; test_mode_i = 0; clkgate_sel_i = 0;
        clkgate_core_i = '0; clkgate_tcdm_i = '0; clkgate_scm_i = 0;
        clkgate_int_i = 0; clkgate_hwacc_i = 0;
        core_busy_i = '0; tcdm_pending_i = '0; wake_i = '0;
`ifdef CLKGATE_SEQ_STATS_EN
        stats_clr_i = 0;
`endif
        step(); step();
        check("rst_core_en", 32'(core_clk_en_o), 32'hF);
        check("rst_tcdm_en", 32'(tcdm_clk_en_o), 32'hF);
        check("rst_gated",   32'(core_gated_o),  32'h0);

        // Core 0 idle with a held request: gate on the 9th edge.
        rst_ni = 1; clkgate_sel_i = 1; clkgate_core_i = 4'b0001;
        for (int k = 1; k <= 10; k++) begin
            step();
            check("gate_c0_en",   32'(core_clk_en_o[0]), (k >= IDLE + 1) ? 32'd0 : 32'd1);
            check("gate_others",  32'(core_clk_en_o[3:1]), 32'h7);
            check("gate_c0_stat", 32'(core_gated_o[0]), 32'd1);
        end

        // One-cycle wake with the request still held.
        wake_i = 4'b0001;
        step();
        check("wake_en",     32'(core_clk_en_o[0]), 32'd1);
        check("wake_gated0", 32'(core_gated_o[0]), 32'd1);
        wake_i = '0;
        step();
        check("wake_gated1", 32'(core_gated_o[0]), 32'd1);
        step();
        check("wake_run",    32'(core_gated_o[0]), 32'd0);
        step();
        check("redrain",     32'(core_gated_o[0]), 32'd1);
        clkgate_core_i = '0;
        step();
        check("drop_req",    32'(core_gated_o[0]), 32'd0);

        // Randomized traffic in chunks of held configuration.
        for (int c = 0; c < 150; c++) begin
            int  len;
            bit  quiet;
            len   = 10 + int'($urandom_range(0, 30));
            quiet = ($urandom_range(0, 2) == 0);
            clkgate_sel_i   = ($urandom_range(0, 7) != 0);
            clkgate_core_i  = 4'($urandom);
            if ($urandom_range(0, 2) == 0) clkgate_core_i = 4'hF;
            clkgate_tcdm_i  = 4'($urandom);
            clkgate_scm_i   = 1'($urandom);
            clkgate_int_i   = 1'($urandom);
            clkgate_hwacc_i = 1'($urandom);
            for (int k = 0; k < len; k++) begin
                @(posedge clk);
                #2;
                for (int i = 0; i < NB; i++) begin
                    core_busy_i[i]    = !quiet && ($urandom_range(0, 9) == 0);
                    tcdm_pending_i[i] = !quiet && ($urandom_range(0, 15) == 0);
                    wake_i[i]         = ($urandom_range(0, 39) == 0);
                end
                test_mode_i = ($urandom_range(0, 15) == 0);
                rst_ni      = ($urandom_range(0, 399) != 0);
`ifdef CLKGATE_SEQ_STATS_EN
                stats_clr_i = ($urandom_range(0, 63) == 0);
`endif
            end
        end

        repeat (3) @(posedge clk);
        #7;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
